// File: rtl/pic_pkg.sv
// pic_pkg: opcode match constants and PC type shared by fetch sequencer and ALU decoder
package pic_pkg;
    typedef logic [7:0] pc_t;
    localparam logic [2:0]  OP_GOTO  = 3'b101;
    localparam logic [3:0]  OP_CALL  = 4'b1001;
    localparam logic [3:0]  OP_RETLW = 4'b1000;
    localparam logic [11:0] NOP_WORD = 12'h000;
endpackage

// File: rtl/pic_stack2.sv
// pic_stack2: two-level hardware return stack; overflow drops oldest, underflow repeats bottom
// Ports: clk, rst (sync active-high), push/pop (never together), din (pushed value), top (current top)
module pic_stack2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top
);
    logic [W-1:0] top_q, top_d, bot_q, bot_d;
    always_comb begin
        top_d = push ? din : pop ? bot_q : top_q;
        bot_d = push ? top_q : bot_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            top_q <= '0;
            bot_q <= '0;
        end else begin
            top_q <= top_d;
            bot_q <= bot_d;
        end
    end
    assign top = top_q;
endmodule

// File: rtl/pic_fetch_seq.sv
// pic_fetch_seq: PC, return stack and registered instruction word for the PIC10F200-class core
// Ports: clk, rst (sync active-high); prog_addr/prog_data to async program ROM;
//        ir_bus/ir_valid to execute; skip_req, pcl_wr/pcl_data, stall from datapath
module pic_fetch_seq
    import pic_pkg::*;
#(
    parameter int              PC_W      = $bits(pc_t),
    parameter logic [PC_W-1:0] RESET_VEC = '1
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] prog_addr,
    input  logic [11:0]     prog_data,
    output logic [11:0]     ir_bus,
    output logic            ir_valid,
    input  logic            skip_req,
    input  logic            pcl_wr,
    input  logic [7:0]      pcl_data,
    input  logic            stall
);
    logic [PC_W-1:0] pc_q, pc_d, stk_top;
    logic [11:0]     ir_q, ir_d;
    logic            v_q, v_d, push, pop;
    logic            is_goto, is_call, is_retlw;
    assign is_goto  = v_q && ir_q[11:9] == OP_GOTO;
    assign is_call  = v_q && ir_q[11:8] == OP_CALL;
    assign is_retlw = v_q && ir_q[11:8] == OP_RETLW;
    // Any redirect or skip replaces the already-fetched word with a NOP bubble.
    always_comb begin
        pc_d = pc_q + PC_W'(1);
        ir_d = prog_data;
        v_d  = 1'b1;
        push = 1'b0;
        pop  = 1'b0;
        if (stall) begin
            pc_d = pc_q;
            ir_d = ir_q;
            v_d  = v_q;
        end else if (is_goto || is_call || is_retlw || (v_q && (pcl_wr || skip_req))) begin
            ir_d = NOP_WORD;
            v_d  = 1'b0;
            push = is_call;
            pop  = is_retlw;
            pc_d = is_goto  ? PC_W'(ir_q[8:0]) :
                   is_call  ? PC_W'(ir_q[7:0]) :
                   is_retlw ? stk_top :
                   pcl_wr   ? PC_W'(pcl_data) : pc_q + PC_W'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_VEC;
            ir_q <= NOP_WORD;
            v_q  <= 1'b0;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
            v_q  <= v_d;
        end
    end
    // pc_q already points past the CALL, so it is the return address.
    pic_stack2 #(.W(PC_W)) u_stack (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  (pc_q),
        .top  (stk_top)
    );
    assign prog_addr = pc_q;
    assign ir_bus    = ir_q;
    assign ir_valid  = v_q;
endmodule

// File: doc/pic_fetch_seq.md
# pic_fetch_seq

Instruction fetch and sequencing unit for the PIC10F200-class core: owns the program counter and the two-level hardware stack, addresses program ROM, and drives the registered instruction word `ir_bus` that the ALU and datapath decode and execute. It sits between the program ROM and the execute stage. It resolves GOTO, CALL, RETLW, computed PCL writes and skip conditions by squashing the instruction already fetched, so every taken control transfer costs exactly one bubble.

## Interface
- `PC_W`, 8, program counter width; program space is 2^PC_W words and addresses wrap modulo 2^PC_W.
- `RESET_VEC`, all ones (8'hFF), PC value loaded on reset; this location holds the calibration MOVLW, then the PC rolls to 0.
- `clk`  in  1  single core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `prog_addr`  out  PC_W  ROM address; combinational copy of the PC register.
- `prog_data`  in  12  ROM word for `prog_addr`, valid in the same cycle (asynchronous ROM).
- `ir_bus`  out  12  registered instruction in execute; squashed slots read 12'h000 (NOP).
- `ir_valid`  out  1  `ir_bus` holds a real fetched instruction (0 = reset or squash bubble).
- `skip_req`  in  1  from datapath during execute of DECFSZ/INCFSZ/BTFSC/BTFSS when the skip condition holds.
- `pcl_wr`  in  1  datapath writes PCL this cycle (computed jump).
- `pcl_data`  in  8  new PCL value, qualified by `pcl_wr`.
- `stall`  in  1  freeze: all registers hold.

## Operation
- Per cycle, absent stall or redirect: `ir_bus <= prog_data`, `ir_valid <= 1`, `pc <= pc + 1` (mod 2^PC_W).
- Control decode acts only on `ir_bus` while `ir_valid = 1`:
  - GOTO `101k_kkkk_kkkk`: `pc <= k[PC_W-1:0]`; squash.
  - CALL `1001_kkkk_kkkk`: push current `pc` (address of CALL + 1); `pc <= {0, k[7:0]}` truncated to PC_W; squash.
  - RETLW `1000_kkkk_kkkk`: `pc <= top`; pop; squash. Loading the literal into W is the datapath's job.
- `pcl_wr`: `pc <= pcl_data` (zero-extended or truncated to PC_W); squash.
- `skip_req` with `ir_valid = 1`: squash; `pc` still increments (no redirect).
- Squash means `ir_bus <= 12'h000`, `ir_valid <= 0` in place of the fetched word.
- Priority: `rst` > `stall` > GOTO/CALL/RETLW > `pcl_wr` > `skip_req` > sequential.
- `skip_req` and `pcl_wr` are ignored when `ir_valid = 0`.
- Stack: two entries, `top` and `bot`.
  - Push: `bot <= top`, `top <= pc`. A third push silently loses the oldest entry.
  - Pop: `top <= bot`, `bot` unchanged. Underflow returns the duplicated `bot`.
  - No overflow or underflow flag.
- Reset values: `pc = RESET_VEC` (so `prog_addr = RESET_VEC`), `ir_bus = 12'h000`, `ir_valid = 0`, `top = bot = 0`. Reset mid-branch or mid-stall discards everything in flight.

## Timing
- Fetch-to-execute latency is 1 cycle: the word at address A appears on `ir_bus` on the edge after `prog_addr == A`.
- A taken transfer (GOTO, CALL, RETLW, PCL write) costs 2 cycles: the transfer itself plus one NOP bubble. The target instruction is in execute 2 cycles after the transfer instruction.
- Skip costs 2 cycles: the skip instruction plus one NOP bubble in place of the skipped word.
- `stall = 1`: `pc`, `ir_bus`, `ir_valid` and the stack hold, and `skip_req`/`pcl_wr` are not sampled. The datapath keeps them asserted until the first non-stalled cycle.
- No combinational path from inputs to outputs except `prog_addr` from the PC register.

## Structure
- Shared package `pic_pkg` holds:
  - opcode match constants/masks: `OP_GOTO` 3'b101, `OP_CALL` 4'b1001, `OP_RETLW` 4'b1000;
  - `NOP_WORD` 12'h000;
  - the `pc_t` typedef.
- These constants are the same ones the ALU decoder uses.
- Sub-module `pic_stack2`: two-level push/pop stack with push, pop, din and top ports, instantiated once. Push and pop are never asserted together.

## Test plan
- Reset: hold `rst` 2 cycles -> `prog_addr = 8'hFF`, `ir_bus = 12'h000`, `ir_valid = 0`. Release -> next `ir_bus = rom[FF]`, `prog_addr = 8'h00` (wrap).
- GOTO: `rom[10] = 12'hAA5` -> `ir_bus = AA5`, then a bubble (`ir_valid = 0`, `rom[11]` never executes), then `ir_bus = rom[A5]`.
- CALL/RETLW: `rom[20] = 12'h940`, `rom[40] = 12'h855` -> execute order 20, bubble, 40, bubble, 21. Stack is empty afterwards.
- Nested overflow: three CALLs from 0x30, 0x50 and 0x60, then three RETLWs -> returns to 0x61, 0x51, then 0x51 again (0x31 lost).
- Skip: `skip_req = 1` while `ir_bus = rom[05]` -> next slot is a NOP bubble, then `rom[07]` executes. `pcl_wr` with `pcl_data = 8'h80` -> bubble, then `rom[80]`.
- Stall: assert `stall` 3 cycles mid-sequence with `skip_req` held -> all outputs frozen. The skip takes effect on the first cycle after release.
